// File: rtl/game_timer_pkg.sv
// Shared types and digit limits for the BCD game timer.
// Optional GAME_TIMER_TIMEOUT_EN adds a minute time limit.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    STOPPED = 2'd3
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/game_timer_bcd_digit.sv
// One BCD digit of the timer carry chain.
// Wraps to zero at max_val and signals carry on that increment.
module bcd_digit
  import game_timer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [BCD_W-1:0] max_val,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);

  assign carry = inc && (digit == max_val);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry ? '0 : digit + 1'b1;
    end
  end

endmodule

// File: rtl/game_timer_bcd.sv
// BCD mm:ss game clock driven by the controller's seconds flag.
// Define GAME_TIMER_TIMEOUT_EN for time_limit_min / timeout.
module game_timer_bcd
  import game_timer_pkg::*;
#(
  parameter int MAX_MINUTES = 99,
  parameter bit TICK_FILTER = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_flag,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             clear,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             running,
  output logic             second_pulse,
  output logic             saturated
`ifdef GAME_TIMER_TIMEOUT_EN
  ,
  input  logic [6:0]       time_limit_min,
  output logic             timeout
`endif
);

  localparam logic [BCD_W-1:0] MAX_T =
    BCD_W'(MAX_MINUTES / 10);
  localparam logic [BCD_W-1:0] MAX_O =
    BCD_W'(MAX_MINUTES % 10);
  localparam logic [BCD_W-1:0] LAST_ONES =
    DIGIT_MAX - 1'b1;

  state_t state, state_n;
  logic   tick_prev;
  logic   tick_rise;
  logic   inc;
  logic   c0, c1, c2, c3;
  logic   at_pre;
  logic   sat_hit;
  logic   to_hit;

  assign tick_rise = TICK_FILTER ?
    (tick_flag & ~tick_prev) : tick_flag;

  assign inc = (state == RUNNING) && tick_rise
            && !clear && !saturated;

  // One second before MAX:59, so saturation lands on the same edge.
  assign at_pre = (min_tens == MAX_T)
               && (min_ones == MAX_O)
               && (sec_tens == SEC_TENS_MAX)
               && (sec_ones == LAST_ONES);

  assign sat_hit = (inc && at_pre) || c3;

`ifdef GAME_TIMER_TIMEOUT_EN
  logic [6:0] min_bin;

  assign min_bin = 7'(min_tens) * 7'd10
                 + 7'(min_ones);

  assign to_hit = inc
               && (time_limit_min != 7'd0)
               && (sec_tens == SEC_TENS_MAX)
               && (sec_ones == DIGIT_MAX)
               && ((min_bin + 7'd1) == time_limit_min);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      timeout <= 1'b0;
    end else if (to_hit) begin
      timeout <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    if (clear) begin
      state_n = IDLE;
    end else begin
      if (stop) begin
        if (state == RUNNING || state == PAUSED)
          state_n = STOPPED;
      end else if (pause) begin
        if (state == RUNNING)
          state_n = PAUSED;
      end else if (start) begin
        if (state == IDLE || state == PAUSED)
          state_n = RUNNING;
      end
      if (to_hit)
        state_n = STOPPED;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      tick_prev    <= 1'b0;
      second_pulse <= 1'b0;
      saturated    <= 1'b0;
    end else begin
      state        <= state_n;
      tick_prev    <= tick_flag;
      second_pulse <= inc;
      if (clear)
        saturated <= 1'b0;
      else if (sat_hit)
        saturated <= 1'b1;
    end
  end

  assign running = (state == RUNNING);

  bcd_digit u_sec_ones (
    .clock   (clock),
    .reset   (reset),
    .clr     (clear),
    .inc     (inc),
    .max_val (DIGIT_MAX),
    .digit   (sec_ones),
    .carry   (c0)
  );

  bcd_digit u_sec_tens (
    .clock   (clock),
    .reset   (reset),
    .clr     (clear),
    .inc     (c0),
    .max_val (SEC_TENS_MAX),
    .digit   (sec_tens),
    .carry   (c1)
  );

  bcd_digit u_min_ones (
    .clock   (clock),
    .reset   (reset),
    .clr     (clear),
    .inc     (c1),
    .max_val (DIGIT_MAX),
    .digit   (min_ones),
    .carry   (c2)
  );

  bcd_digit u_min_tens (
    .clock   (clock),
    .reset   (reset),
    .clr     (clear),
    .inc     (c2),
    .max_val (DIGIT_MAX),
    .digit   (min_tens),
    .carry   (c3)
  );

endmodule
